// File: rtl/uart_framed.sv
// Single-clock UART: baud-divided framed transmitter and mid-bit sampling receiver
// with valid/ready toward the core and per-word error flags.
module uart_framed #(
  parameter int unsigned word_size = 8,
  parameter int unsigned BAUD_DIV  = 16,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 internal_clk,
  input  logic                 rst_n,
  input  logic [word_size-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 bit_from_UART,
  input  logic                 bit_to_UART,
  output logic [word_size-1:0] word_from_UART,
  output logic                 rx_valid,
  input  logic                 read,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun
);

  localparam int unsigned BAUD_W = $clog2(BAUD_DIV);
  localparam int unsigned BIT_W  = 4;
  localparam logic HAS_PAR = (PARITY != 0);
  localparam logic ODD_PAR = (PARITY == 2);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(BAUD_DIV / 2 - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(word_size - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t               r_tx_state;
  logic [BAUD_W-1:0]    r_tx_baud;
  logic [BIT_W-1:0]     r_tx_bits;
  logic [word_size-1:0] r_tx_shift;
  logic                 r_tx_par;
  logic                 r_tx_line;
  logic                 r_tx_ready;

  state_t               r_rx_state;
  logic [2:0]           r_rx_sync;
  logic [BAUD_W-1:0]    r_rx_baud;
  logic [BIT_W-1:0]     r_rx_bits;
  logic [word_size-1:0] r_rx_shift;
  logic                 r_rx_par;
  logic [word_size-1:0] r_rx_word;
  logic                 r_rx_valid;
  logic                 r_rx_ferr;
  logic                 r_rx_perr;
  logic                 r_rx_ovr;

  logic w_rx_in;
  logic w_rx_fall;

  // [0],[1] form the synchroniser; [2] is the previous synchronised level for edge detect
  assign w_rx_in   = r_rx_sync[1];
  assign w_rx_fall = r_rx_sync[2] & ~r_rx_sync[1];

  assign tx_ready       = r_tx_ready;
  assign bit_from_UART  = r_tx_line;
  assign word_from_UART = r_rx_word;
  assign rx_valid       = r_rx_valid;
  assign rx_frame_err   = r_rx_ferr;
  assign rx_parity_err  = r_rx_perr;
  assign rx_overrun     = r_rx_ovr;

  // Transmitter: the line register always holds the bit of the current bit time
  always_ff @(posedge internal_clk) begin
    if (!rst_n) begin
      r_tx_state <= ST_IDLE;
      r_tx_baud  <= '0;
      r_tx_bits  <= '0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_tx_line  <= 1'b1;
      r_tx_ready <= 1'b1;
    end else begin
      case (r_tx_state)
        ST_IDLE: begin
          if (tx_valid && r_tx_ready) begin
            r_tx_state <= ST_START;
            r_tx_shift <= tx_data;
            r_tx_par   <= (^tx_data) ^ ODD_PAR;
            r_tx_baud  <= '0;
            r_tx_line  <= 1'b0;
            r_tx_ready <= 1'b0;
          end
        end
        default: begin
          if (r_tx_baud != BAUD_LAST) begin
            r_tx_baud <= r_tx_baud + BAUD_W'(1);
          end else begin
            r_tx_baud <= '0;
            case (r_tx_state)
              ST_START: begin
                r_tx_state <= ST_DATA;
                r_tx_line  <= r_tx_shift[0];
                r_tx_shift <= r_tx_shift >> 1;
                r_tx_bits  <= '0;
              end
              ST_DATA: begin
                if (r_tx_bits == DATA_LAST) begin
                  r_tx_bits <= '0;
                  if (HAS_PAR) begin
                    r_tx_state <= ST_PARITY;
                    r_tx_line  <= r_tx_par;
                  end else begin
                    r_tx_state <= ST_STOP;
                    r_tx_line  <= 1'b1;
                  end
                end else begin
                  r_tx_line  <= r_tx_shift[0];
                  r_tx_shift <= r_tx_shift >> 1;
                  r_tx_bits  <= r_tx_bits + BIT_W'(1);
                end
              end
              ST_PARITY: begin
                r_tx_state <= ST_STOP;
                r_tx_line  <= 1'b1;
                r_tx_bits  <= '0;
              end
              ST_STOP: begin
                if (r_tx_bits == STOP_LAST) begin
                  r_tx_state <= ST_IDLE;
                  r_tx_ready <= 1'b1;
                end else begin
                  r_tx_bits <= r_tx_bits + BIT_W'(1);
                end
                r_tx_line <= 1'b1;
              end
              default: begin
                r_tx_state <= ST_IDLE;
                r_tx_line  <= 1'b1;
                r_tx_ready <= 1'b1;
              end
            endcase
          end
        end
      endcase
    end
  end

  // Receiver: half a bit after the start edge, then one sample per bit time (mid-bit)
  always_ff @(posedge internal_clk) begin
    if (!rst_n) begin
      r_rx_state <= ST_IDLE;
      r_rx_sync  <= 3'b111;
      r_rx_baud  <= '0;
      r_rx_bits  <= '0;
      r_rx_shift <= '0;
      r_rx_par   <= 1'b0;
      r_rx_word  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
      r_rx_perr  <= 1'b0;
      r_rx_ovr   <= 1'b0;
    end else begin
      r_rx_sync <= {r_rx_sync[1:0], bit_to_UART};
      if (read && r_rx_valid) begin
        r_rx_valid <= 1'b0;
        r_rx_ovr   <= 1'b0;
      end
      case (r_rx_state)
        ST_IDLE: begin
          if (w_rx_fall) begin
            r_rx_state <= ST_START;
            r_rx_baud  <= '0;
          end
        end
        ST_START: begin
          if (r_rx_baud == BAUD_HALF) begin
            r_rx_baud  <= '0;
            r_rx_bits  <= '0;
            r_rx_state <= w_rx_in ? ST_IDLE : ST_DATA;
          end else begin
            r_rx_baud <= r_rx_baud + BAUD_W'(1);
          end
        end
        ST_DATA: begin
          if (r_rx_baud == BAUD_LAST) begin
            r_rx_baud  <= '0;
            r_rx_shift <= {w_rx_in, r_rx_shift[word_size-1:1]};
            r_rx_bits  <= r_rx_bits + BIT_W'(1);
            if (r_rx_bits == DATA_LAST) begin
              r_rx_state <= HAS_PAR ? ST_PARITY : ST_STOP;
            end
          end else begin
            r_rx_baud <= r_rx_baud + BAUD_W'(1);
          end
        end
        ST_PARITY: begin
          if (r_rx_baud == BAUD_LAST) begin
            r_rx_baud  <= '0;
            r_rx_par   <= w_rx_in;
            r_rx_state <= ST_STOP;
          end else begin
            r_rx_baud <= r_rx_baud + BAUD_W'(1);
          end
        end
        ST_STOP: begin
          // Only the first stop bit is checked, so the next start edge is caught with no gap
          if (r_rx_baud == BAUD_LAST) begin
            r_rx_baud  <= '0;
            r_rx_state <= ST_IDLE;
            r_rx_word  <= r_rx_shift;
            r_rx_ferr  <= ~w_rx_in;
            r_rx_perr  <= HAS_PAR & ((^r_rx_shift) ^ r_rx_par ^ ODD_PAR);
            r_rx_valid <= 1'b1;
            r_rx_ovr   <= r_rx_valid & ~read;
          end else begin
            r_rx_baud <= r_rx_baud + BAUD_W'(1);
          end
        end
        default: r_rx_state <= ST_IDLE;
      endcase
    end
  end

endmodule
